// File: rtl/psum_accum.sv
// Partial-sum loop controller for the mac datapath: accumulates K mac results per output
// element, then rounds, shifts and saturates the accumulator to INT8 for the output buffer.
module psum_accum #(
    parameter int K_W   = 8,
    parameter int ACC_W = 24,
    parameter int OUT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_mode,
    input  logic             i_start,
    input  logic [K_W-1:0]   i_k_len,
    input  logic [4:0]       i_shift,
    output logic [ACC_W-1:0] o_psum,
    input  logic             i_res_valid,
    output logic             o_res_ready,
    input  logic [ACC_W-1:0] i_result,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_out_data,
    output logic             o_busy
);

    localparam logic [1:0] MODE_INT4_VSQ = 2'd2;
    localparam int WIDE_W = ACC_W + 8;
    localparam logic signed [WIDE_W:0] SAT_MAX = (WIDE_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [WIDE_W:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FINAL = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                   state, state_nxt;
    logic signed [ACC_W-1:0]  acc;
    logic [K_W-1:0]           cnt;
    logic [K_W-1:0]           k_len_q;
    logic [1:0]               mode_q;
    logic [4:0]               shift_q;
    logic signed [WIDE_W-1:0] wide;
    logic                     accept;
    logic                     last_accept;

    // One extra bit of headroom so the rounding offset cannot overflow a full-scale VSQ value.
    function automatic logic signed [WIDE_W:0] round_shift(
        input logic signed [WIDE_W-1:0] w,
        input logic [4:0]               sh
    );
        logic signed [WIDE_W:0] r;
        r = (WIDE_W+1)'(w);
        if (sh != 5'd0)
            r = r + ((WIDE_W+1)'(1) <<< (sh - 5'd1));
        return r >>> sh;
    endfunction

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [WIDE_W:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    always_comb begin
        o_res_ready = (state == ACCUM);
        o_busy      = (state != IDLE);
        accept      = o_res_ready && i_res_valid;
        last_accept = accept && (cnt == k_len_q - K_W'(1));
        // The mac leaves the VSQ scale shift to us, applied before requantization.
        if (mode_q == MODE_INT4_VSQ)
            wide = $signed({acc, 8'd0});
        else
            wide = WIDE_W'(acc);

        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = (i_k_len != '0) ? ACCUM : FINAL;
            ACCUM:   if (last_accept) state_nxt = FINAL;
            FINAL:   state_nxt = OUT;
            OUT:     if (i_out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            k_len_q     <= '0;
            mode_q      <= '0;
            shift_q     <= '0;
            o_psum      <= '0;
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        mode_q  <= i_mode;
                        k_len_q <= i_k_len;
                        shift_q <= i_shift;
                        acc     <= '0;
                        cnt     <= '0;
                        o_psum  <= '0;
                    end
                end
                ACCUM: begin
                    // o_psum mirrors the accumulator only while the loop is still open.
                    if (accept) begin
                        acc    <= i_result;
                        cnt    <= cnt + K_W'(1);
                        o_psum <= last_accept ? '0 : i_result;
                    end
                end
                FINAL: begin
                    o_out_data  <= saturate(round_shift(wide, shift_q));
                    o_out_valid <= 1'b1;
                end
                OUT: begin
                    if (i_out_ready) begin
                        o_out_valid <= 1'b0;
                        acc         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: hand-computed requant vectors, backpressure, gaps and reset.
module tb_psum_accum;

    localparam logic [1:0] M_INT8 = 2'd0;
    localparam logic [1:0] M_VSQ  = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  mode;
    logic        start;
    logic [7:0]  k_len;
    logic [4:0]  shift;
    logic [23:0] psum;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] result;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    psum_accum dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_mode      (mode),
        .i_start     (start),
        .i_k_len     (k_len),
        .i_shift     (shift),
        .o_psum      (psum),
        .i_res_valid (res_valid),
        .o_res_ready (res_ready),
        .i_result    (result),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One k_len=1 element; i_mode is changed right after start to prove the latched copy is used.
    task automatic single(input string tag, input logic [1:0] m, input logic [4:0] sh,
                          input int res, input logic [7:0] exp);
        mode = m; k_len = 8'd1; shift = sh; start = 1'b1;
        tick();
        start = 1'b0;
        mode  = ~m;
        res_valid = 1'b1; result = 24'(res);
        tick();
        res_valid = 1'b0;
        chk({tag, "_final_valid"}, out_valid, 1'b0);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; mode = M_INT8; start = 1'b0; k_len = '0; shift = '0;
        res_valid = 1'b0; result = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'd0);
        chk("rst_psum", psum, 24'd0);
        chk("rst_ready", res_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // INT8, three chunks: psum walks 0, 10, 30 and the output is the last result.
        mode = M_INT8; k_len = 8'd3; shift = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_ready", res_ready, 1'b1);
        chk("t1_psum0", psum, 24'd0);
        res_valid = 1'b1; result = 24'd10;
        tick();
        chk("t1_psum1", psum, 24'd10);
        result = 24'd30;
        tick();
        chk("t1_psum2", psum, 24'd30);
        result = 24'd60;
        tick();
        res_valid = 1'b0;
        chk("t1_final_ready", res_ready, 1'b0);
        chk("t1_final_busy", busy, 1'b1);
        chk("t1_final_psum", psum, 24'd0);
        tick();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_data, 8'd60);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_done_valid", out_valid, 1'b0);
        chk("t1_done_busy", busy, 1'b0);

        // Requant vectors.
        single("t2_vsq", M_VSQ, 5'd8, -3, 8'hFD);
        single("t3_round", M_INT8, 5'd4, 1000, 8'd63);
        single("t3_satpos", M_INT8, 5'd4, 5000, 8'd127);
        single("t3_satneg", M_INT8, 5'd4, -5000, 8'h80);
        single("t3_noshift", M_INT8, 5'd0, 200, 8'd127);
        single("t3_vsq12", M_VSQ, 5'd12, 100, 8'd6);
        single("t3_vsqmax", M_VSQ, 5'd31, 8388607, 8'd1);

        // Backpressure: output held, starts ignored, no result acceptance.
        mode = M_INT8; k_len = 8'd1; shift = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        res_valid = 1'b1; result = 24'd5;
        tick();
        res_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            start = i[0]; k_len = 8'd2;
            tick();
            chk("t4_hold_valid", out_valid, 1'b1);
            chk("t4_hold_data", out_data, 8'd5);
            chk("t4_hold_ready", res_ready, 1'b0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_release_busy", busy, 1'b0);
        chk("t4_release_valid", out_valid, 1'b0);
        chk("t4_retained_data", out_data, 8'd5);
        tick();
        chk("t4_no_restart", busy, 1'b0);

        // Gaps in result valid: exactly two accepts close the element.
        k_len = 8'd2; shift = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        res_valid = 1'b1; result = 24'd7;
        tick();
        chk("t5_psum_a", psum, 24'd7);
        res_valid = 1'b0; result = 24'd99;
        tick();
        chk("t5_gap1", psum, 24'd7);
        tick();
        chk("t5_gap2_ready", res_ready, 1'b1);
        res_valid = 1'b1; result = 24'd20;
        tick();
        result = 24'd44;
        chk("t5_closed", res_ready, 1'b0);
        tick();
        res_valid = 1'b0;
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_data", out_data, 8'd20);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of an element, then a zero-length element.
        k_len = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        res_valid = 1'b1; result = 24'd50;
        tick();
        res_valid = 1'b0;
        chk("t6_psum", psum, 24'd50);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_psum", psum, 24'd0);
        chk("t6_rst_ready", res_ready, 1'b0);
        chk("t6_rst_data", out_data, 8'd0);
        chk("t6_rst_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        mode = M_INT8; k_len = 8'd0; shift = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_k0_final", out_valid, 1'b0);
        chk("t6_k0_busy", busy, 1'b1);
        tick();
        chk("t6_k0_valid", out_valid, 1'b1);
        chk("t6_k0_data", out_data, 8'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t6_k0_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
